// File: rtl/mycpu_pkg.sv
// Shared types and default constants for the CPU bus interface unit.
// The ERR state exists only when CPU_BIU_TIMEOUT_EN is defined.
package mycpu_pkg;

    localparam int unsigned BIU_DATA_W  = 16;
    localparam int unsigned BIU_ADDR_W  = 16;
    localparam int unsigned BIU_TMO_W   = 8;
    localparam int unsigned BIU_TMO_MAX = 255;

`ifdef CPU_BIU_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} biu_state_t;
`else
    typedef enum logic [1:0] {StIdle, StBusy, StDone} biu_state_t;
`endif

endpackage

// File: rtl/cpu_biu_if.sv
// Core-side and bus-side signals of the BIU; master = the BIU, slave = core plus bus target.
interface cpu_biu_if
    import mycpu_pkg::*;
#(
    parameter int unsigned DATA_W = BIU_DATA_W,
    parameter int unsigned ADDR_W = BIU_ADDR_W
);
    logic              core_req;
    logic              core_wen;
    logic              core_iom;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_done;
    logic              core_stall;
    logic              core_err;
    logic              bus_req;
    logic              bus_wen;
    logic              bus_iom;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        input  core_req, core_wen, core_iom, core_addr, core_wdata, bus_rdata, bus_ack,
        output core_rdata, core_done, core_stall, core_err,
        output bus_req, bus_wen, bus_iom, bus_addr, bus_wdata
    );

    modport slave (
        output core_req, core_wen, core_iom, core_addr, core_wdata, bus_rdata, bus_ack,
        input  core_rdata, core_done, core_stall, core_err,
        input  bus_req, bus_wen, bus_iom, bus_addr, bus_wdata
    );

endinterface

// File: rtl/biu_tmo_cnt.sv
// Counts BUSY cycles without ack; hit flags the cycle in which the count reaches TMO_MAX.
module biu_tmo_cnt #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    // cnt_q holds the number of already elapsed wait cycles, so this is the TMO_MAX-th one.
    assign hit = en && (cnt_q == TMO_W'(TMO_MAX - 1));

endmodule

// File: rtl/cpu_biu.sv
// CPU bus interface unit: registers a core request onto the bus and waits for the slave ack.
// Optional ack timeout with abort is enabled by defining CPU_BIU_TIMEOUT_EN.
module cpu_biu
    import mycpu_pkg::*;
#(
    parameter int unsigned DATA_W  = BIU_DATA_W,
    parameter int unsigned ADDR_W  = BIU_ADDR_W,
    parameter int unsigned TMO_W   = BIU_TMO_W,
    parameter int unsigned TMO_MAX = BIU_TMO_MAX
) (
    input logic       clk,
    input logic       rst,
    cpu_biu_if.master bif
);

    biu_state_t        state_q;
    logic              req_q;
    logic              wen_q;
    logic              iom_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              tmo_hit;

`ifdef CPU_BIU_TIMEOUT_EN
    logic err_q;

    biu_tmo_cnt #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q == StIdle && bif.core_req),
        .en  (state_q == StBusy && !bif.bus_ack),
        .hit (tmo_hit)
    );

    assign bif.core_err = err_q;
`else
    assign tmo_hit      = 1'b0;
    assign bif.core_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            iom_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
`ifdef CPU_BIU_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef CPU_BIU_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bif.core_req) begin
                        wen_q   <= bif.core_wen;
                        iom_q   <= bif.core_iom;
                        addr_q  <= bif.core_addr;
                        wdata_q <= bif.core_wdata;
                        req_q   <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (bif.bus_ack) begin
                        if (!wen_q) begin
                            rdata_q <= bif.bus_rdata;
                        end
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
`ifdef CPU_BIU_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        rdata_q <= '1;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= StErr;
`endif
                    end
                end
                StDone: state_q <= StIdle;
`ifdef CPU_BIU_TIMEOUT_EN
                StErr:  state_q <= StIdle;
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef CPU_BIU_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = tmo_hit;
`endif

    // Stall must react to core_req in the same cycle, so it is the one combinational output.
    assign bif.core_stall = !rst && ((state_q == StIdle && bif.core_req) || state_q == StBusy);
    assign bif.core_rdata = rdata_q;
    assign bif.core_done  = done_q;
    assign bif.bus_req    = req_q;
    assign bif.bus_wen    = wen_q;
    assign bif.bus_iom    = iom_q;
    assign bif.bus_addr   = addr_q;
    assign bif.bus_wdata  = wdata_q;

endmodule

// File: doc/cpu_biu.md
CPU_BIU -- requirements
Module: cpu_biu

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, data word width.
- ADDR_W, default 16, address width.
- TMO_W, default 8, timeout counter width.
- TMO_MAX, default 255, cycles waited for bus_ack before abort.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, reset, synchronous and active-high.
- core_req, in, 1, core requests a transfer.
- core_wen, in, 1, 1=write, 0=read.
- core_iom, in, 1, 1=IO space, 0=memory space.
- core_addr, in, ADDR_W, transfer address.
- core_wdata, in, DATA_W, write data.
- core_rdata, out, DATA_W, read data, valid while core_done=1.
- core_done, out, 1, one-cycle completion pulse.
- core_stall, out, 1, core must hold its state.
- core_err, out, 1, one-cycle timeout-abort pulse.
- bus_req, out, 1, bus transfer strobe.
- bus_wen, out, 1, registered copy of core_wen.
- bus_iom, out, 1, registered copy of core_iom.
- bus_addr, out, ADDR_W, registered address.
- bus_wdata, out, DATA_W, registered write data.
- bus_rdata, in, DATA_W, read data from the slave.
- bus_ack, in, 1, slave completion, one cycle or longer.

Function
REQ-003 The FSM SHALL have the states IDLE, BUSY, DONE and ERR, one-hot or binary encoded.
REQ-004 In IDLE with core_req=1, the block SHALL capture core_wen, core_iom, core_addr and core_wdata into the bus_* registers and go to BUSY next cycle.
REQ-005 In BUSY, bus_req SHALL be 1 and the bus_* outputs SHALL stay stable until the state is left.
REQ-006 In BUSY with bus_ack=1, a read SHALL latch bus_rdata into core_rdata, and the FSM SHALL go to DONE.
REQ-007 DONE SHALL last exactly one cycle with core_done=1, then the FSM SHALL return to IDLE.
REQ-008 A new core_req seen in DONE SHALL be ignored; the core re-asserts it in IDLE, so at most one transfer runs per 3 cycles.
REQ-009 Minimum latency SHALL be req accepted at cycle N, bus_req at N+1, ack at N+1, core_done at N+2.
REQ-010 core_stall SHALL be 1 when (IDLE and core_req) or BUSY, and 0 otherwise.
REQ-011 core_rdata SHALL hold its last latched value outside DONE; writes SHALL NOT alter it.
REQ-012 bus_ack received in IDLE, DONE or ERR SHALL be ignored, with no state change.
REQ-013 bus_ack arriving in the same cycle as a timeout (REQ-016) SHALL take priority: the transfer completes normally.

Reset
REQ-014 While rst=1 at a clock edge, the block SHALL enter IDLE and clear every output and register to 0 (core_rdata, bus_addr, bus_wdata, bus_wen, bus_iom, bus_req, core_done, core_err, core_stall, timeout counter).
REQ-015 A reset asserted during BUSY SHALL abort the transfer; bus_req SHALL be 0 in the first cycle after the reset edge, with no done or err pulse.

Configuration
REQ-016 With macro CPU_BIU_TIMEOUT_EN defined:
- a TMO_W-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
- when it reaches TMO_MAX, the FSM SHALL go to ERR, drop bus_req, and load core_rdata with all ones.
- ERR SHALL last one cycle with core_err=1 and core_done=1, then the FSM SHALL go to IDLE.
REQ-017 Without CPU_BIU_TIMEOUT_EN:
- there SHALL be no counter and no ERR state.
- core_err SHALL be tied to 0.
- BUSY SHALL wait indefinitely for bus_ack.

Structure
REQ-018 The state enum type (biu_state_t) and default parameter constants SHALL live in the shared package mycpu_pkg.
REQ-019 The timeout counter SHALL be the sub-module biu_tmo_cnt (ports: clk, rst, clr, en, hit), instantiated only under CPU_BIU_TIMEOUT_EN.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Read, zero wait: addr=0x1234, iom=0, ack in first BUSY cycle with rdata=0xBEEF -> core_done 2 cycles after req, core_rdata=0xBEEF, bus_wen=0.
- Write, 5 wait states: addr=0x00F0, wdata=0xA5A5, iom=1 -> bus_* stable 6 BUSY cycles; core_stall=1 throughout; core_done once; core_rdata unchanged.
- Timeout (macro on, TMO_MAX=4), no ack -> ERR after 4 BUSY cycles; core_err=core_done=1 for one cycle; core_rdata=0xFFFF.
- Ack and timeout in the same cycle (TMO_MAX=4, ack at 4th BUSY cycle, rdata=0x0001) -> normal done, core_err=0, core_rdata=0x0001.
- rst=1 mid-BUSY -> next cycle bus_req=0, all outputs 0, FSM in IDLE; a later req completes normally.
- Back-to-back: core_req held high across two transfers -> second req accepted only in IDLE after DONE; stray ack in IDLE ignored.
